// File: rtl/msrv32_pkg.sv
// Shared encodings and types for the msrv32 writeback stage.
// Writeback-source and load-size encodings, the stage FSM states and the captured-instruction bundle.
// Pure declarations; no timing or flow-control behaviour lives here.
package msrv32_pkg;

    localparam int XLEN      = 32;
    localparam int RF_ADDR_W = 5;

    // Writeback source select; codes 5..7 are unused and fall back to the ALU result.
    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_LOAD = 3'd1;
    localparam logic [2:0] WB_IMM  = 3'd2;
    localparam logic [2:0] WB_PC4  = 3'd3;
    localparam logic [2:0] WB_CSR  = 3'd4;

    // Load access size; code 3 is unused and behaves as a word.
    localparam logic [1:0] LOAD_B = 2'd0;
    localparam logic [1:0] LOAD_H = 2'd1;
    localparam logic [1:0] LOAD_W = 2'd2;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HOLD      = 2'd1,
        LOAD_WAIT = 2'd2
    } wb_state_e;

    // Everything the stage needs to retire one instruction.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd_addr;
        logic                 rf_wr_en;
        logic [2:0]           wb_sel;
        logic [XLEN-1:0]      alu;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      pc4;
        logic [XLEN-1:0]      csr;
        logic [1:0]           load_size;
        logic                 load_unsigned;
    } wb_instr_t;

    // Extend a 16-bit field to XLEN; a byte load passes its byte in the low 8 bits.
    function automatic logic [XLEN-1:0] load_extend(input logic [15:0] val,
                                                    input logic        is_half,
                                                    input logic        is_unsigned);
        logic sign;
        sign = is_unsigned ? 1'b0 : (is_half ? val[15] : val[7]);
        return is_half ? {{(XLEN-16){sign}}, val} : {{(XLEN-8){sign}}, val[7:0]};
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load data aligner: picks the addressed byte/half/word out of the memory word and extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [XLEN-1:0] dmdata_in,
    input  logic [1:0]      offset_in,
    input  logic [1:0]      size_in,
    input  logic            unsigned_in,
    output logic [XLEN-1:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select and extension; halfword ignores offset[0] since misaligned halves trap earlier.
    always_comb begin
        byte_sel = dmdata_in[7:0];
        case (offset_in)
            2'd0:    byte_sel = dmdata_in[7:0];
            2'd1:    byte_sel = dmdata_in[15:8];
            2'd2:    byte_sel = dmdata_in[23:16];
            default: byte_sel = dmdata_in[31:24];
        endcase
        half_sel = offset_in[1] ? dmdata_in[31:16] : dmdata_in[15:0];
        case (size_in)
            LOAD_B:  data_out = load_extend({8'd0, byte_sel}, 1'b0, unsigned_in);
            LOAD_H:  data_out = load_extend(half_sel, 1'b1, unsigned_in);
            default: data_out = dmdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_wb_stage.sv
// Writeback stage: registers one retiring instruction and drives the integer-file write port.
// Latency: captured at edge N, write presented during cycle N+1 (loads: the cycle dmvalid arrives).
// Backpressure: stall_out is raised while a captured load has no data; nothing is captured meanwhile.
module msrv32_wb_stage
    import msrv32_pkg::*;
(
    input  logic                 ms_riscv32_mp_clk_in,
    input  logic                 ms_riscv32_mp_rst_in,
    input  logic                 ex_valid_in,
    input  logic                 flush_in,
    input  logic [RF_ADDR_W-1:0] rd_addr_in,
    input  logic                 rf_wr_en_in,
    input  logic [2:0]           wb_mux_sel_in,
    input  logic [XLEN-1:0]      alu_result_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic [XLEN-1:0]      pc_plus_4_in,
    input  logic [XLEN-1:0]      csr_data_in,
    input  logic [1:0]           load_size_in,
    input  logic                 load_unsigned_in,
    input  logic [XLEN-1:0]      ms_riscv32_mp_dmdata_in,
    input  logic                 ms_riscv32_mp_dmvalid_in,
    output logic [RF_ADDR_W-1:0] rd_addr_out,
    output logic                 wr_en_out,
    output logic [XLEN-1:0]      rd_out,
    output logic                 stall_out
);

    wb_state_e state_q, state_d;
    wb_instr_t instr_q, instr_d;

    logic            capture;
    logic            retire;
    logic [XLEN-1:0] load_val;

    msrv32_load_align u_load_align (
        .dmdata_in   (ms_riscv32_mp_dmdata_in),
        .offset_in   (instr_q.alu[1:0]),
        .size_in     (instr_q.load_size),
        .unsigned_in (instr_q.load_unsigned),
        .data_out    (load_val)
    );

    // Flow control: a pending load holds off upstream until its data shows up.
    always_comb begin
        stall_out = (state_q == LOAD_WAIT) && !ms_riscv32_mp_dmvalid_in;
        capture   = ex_valid_in && !flush_in && !stall_out;
        retire    = (state_q == HOLD) || ((state_q == LOAD_WAIT) && ms_riscv32_mp_dmvalid_in);
    end

    // Next state and capture of the incoming instruction; an unanswered load keeps waiting.
    always_comb begin
        state_d = EMPTY;
        instr_d = instr_q;
        if (capture) begin
            state_d               = (wb_mux_sel_in == WB_LOAD) ? LOAD_WAIT : HOLD;
            instr_d.rd_addr       = rd_addr_in;
            instr_d.rf_wr_en      = rf_wr_en_in;
            instr_d.wb_sel        = wb_mux_sel_in;
            instr_d.alu           = alu_result_in;
            instr_d.imm           = imm_in;
            instr_d.pc4           = pc_plus_4_in;
            instr_d.csr           = csr_data_in;
            instr_d.load_size     = load_size_in;
            instr_d.load_unsigned = load_unsigned_in;
        end else if (stall_out) begin
            state_d = LOAD_WAIT;
        end
    end

    // State and pipeline registers; reset drops any outstanding load.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q <= EMPTY;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    // Register-file port: source mux, and never a write to x0.
    always_comb begin
        rd_addr_out = '0;
        rd_out      = '0;
        wr_en_out   = retire && instr_q.rf_wr_en && (instr_q.rd_addr != '0);
        if (state_q != EMPTY) begin
            rd_addr_out = instr_q.rd_addr;
            case (instr_q.wb_sel)
                WB_LOAD: rd_out = load_val;
                WB_IMM:  rd_out = instr_q.imm;
                WB_PC4:  rd_out = instr_q.pc4;
                WB_CSR:  rd_out = instr_q.csr;
                default: rd_out = instr_q.alu;
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_wb_stage.sv
module tb_msrv32_wb_stage;
    import msrv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_in, flush_in, rf_wr_en_in, load_unsigned_in, dmvalid;
    logic [4:0]  rd_addr_in;
    logic [2:0]  wb_mux_sel_in;
    logic [31:0] alu_result_in, imm_in, pc_plus_4_in, csr_data_in, dmdata;
    logic [1:0]  load_size_in;
    logic [4:0]  rd_addr_out;
    logic        wr_en_out, stall_out;
    logic [31:0] rd_out;

    int total = 0;
    int bad   = 0;

    // Integer-file stand-in fed by the write port.
    bit [31:0] tb_rf [32];
    bit        x0_written;
    // Expected register contents for the random phase.
    bit [31:0] model_rf [32];
    bit        touched  [32];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en_out) begin
            tb_rf[rd_addr_out] <= rd_out;
            if (rd_addr_out == 5'd0) x0_written <= 1'b1;
        end
    end

    msrv32_wb_stage dut (
        .ms_riscv32_mp_clk_in     (clk),
        .ms_riscv32_mp_rst_in     (rst),
        .ex_valid_in              (ex_valid_in),
        .flush_in                 (flush_in),
        .rd_addr_in               (rd_addr_in),
        .rf_wr_en_in              (rf_wr_en_in),
        .wb_mux_sel_in            (wb_mux_sel_in),
        .alu_result_in            (alu_result_in),
        .imm_in                   (imm_in),
        .pc_plus_4_in             (pc_plus_4_in),
        .csr_data_in              (csr_data_in),
        .load_size_in             (load_size_in),
        .load_unsigned_in         (load_unsigned_in),
        .ms_riscv32_mp_dmdata_in  (dmdata),
        .ms_riscv32_mp_dmvalid_in (dmvalid),
        .rd_addr_out              (rd_addr_out),
        .wr_en_out                (wr_en_out),
        .rd_out                   (rd_out),
        .stall_out                (stall_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic wen, input logic [2:0] sel,
                             input logic [31:0] alu, input logic [31:0] imm,
                             input logic [31:0] pc4, input logic [31:0] csr,
                             input logic [1:0] sz, input logic uns);
        ex_valid_in      = 1'b1;
        rd_addr_in       = rd;
        rf_wr_en_in      = wen;
        wb_mux_sel_in    = sel;
        alu_result_in    = alu;
        imm_in           = imm;
        pc_plus_4_in     = pc4;
        csr_data_in      = csr;
        load_size_in     = sz;
        load_unsigned_in = uns;
    endtask

    // Architectural result of an instruction, from the ISA load rules.
    function automatic logic [31:0] ref_rd(input logic [2:0] sel, input logic [31:0] alu,
                                           input logic [31:0] imm, input logic [31:0] pc4,
                                           input logic [31:0] csr, input logic [31:0] dm,
                                           input logic [1:0] sz, input logic uns);
        int unsigned off;
        logic [31:0] v;
        off = alu % 4;
        v   = alu;
        if (sel == 3'd1) begin
            if (sz == 2'd0) begin
                v = (dm >> (off * 8)) & 32'hFF;
                if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (dm >> ((off / 2) * 16)) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
            end else begin
                v = dm;
            end
        end else if (sel == 3'd2) v = imm;
        else if (sel == 3'd3) v = pc4;
        else if (sel == 3'd4) v = csr;
        return v;
    endfunction

    initial begin
        logic [4:0]  r_rd;
        logic        r_wen, r_uns, r_fl, r_exp;
        logic [2:0]  r_sel;
        logic [1:0]  r_sz;
        logic [31:0] r_alu, r_imm, r_pc4, r_csr, r_dm, r_val;
        int          r_dly;

        rst = 1'b1; ex_valid_in = 1'b0; flush_in = 1'b0; dmvalid = 1'b0; dmdata = '0;
        set_instr(5'd0, 1'b0, WB_ALU, '0, '0, '0, '0, LOAD_B, 1'b0);
        ex_valid_in = 1'b0;
        repeat (2) step();
        #1;
        chk("reset_wr_en", wr_en_out, 0);
        chk("reset_rd_addr", rd_addr_out, 0);
        chk("reset_rd_out", rd_out, 0);
        chk("reset_stall", stall_out, 0);
        rst = 1'b0;

        // ALU op to x5
        set_instr(5'd5, 1'b1, WB_ALU, 32'h1234_5678, 32'h1, 32'h2, 32'h3, LOAD_W, 1'b0);
        step(); ex_valid_in = 1'b0; #1;
        chk("alu_wr_en", wr_en_out, 1);
        chk("alu_rd_addr", rd_addr_out, 5);
        chk("alu_rd_out", rd_out, 32'h1234_5678);
        step(); #1;
        chk("alu_rf_x5", tb_rf[5], 32'h1234_5678);
        chk("alu_empty_wr_en", wr_en_out, 0);
        chk("alu_empty_rd_out", rd_out, 0);
        chk("alu_empty_rd_addr", rd_addr_out, 0);

        // x0 destination is never written
        set_instr(5'd0, 1'b1, WB_IMM, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, LOAD_W, 1'b0);
        step(); ex_valid_in = 1'b0; #1;
        chk("x0_wr_en", wr_en_out, 0);
        chk("x0_rd_out", rd_out, 32'hDEAD_BEEF);
        step(); #1;
        chk("x0_wr_en_after", wr_en_out, 0);
        chk("x0_rf", tb_rf[0], 0);
        chk("x0_written", x0_written, 0);

        // LB / LBU offset 3 with dmvalid three cycles late
        for (int u = 0; u < 2; u++) begin
            set_instr(5'd11, 1'b1, WB_LOAD, 32'h1000_0003, 0, 0, 0, LOAD_B, u[0]);
            dmdata = 32'h80AA_BBCC;
            step(); ex_valid_in = 1'b0;
            for (int d = 0; d < 3; d++) begin
                #1;
                chk("lb_stall", stall_out, 1);
                chk("lb_wait_wr_en", wr_en_out, 0);
                step();
            end
            dmvalid = 1'b1; #1;
            chk("lb_stall_done", stall_out, 0);
            chk("lb_wr_en", wr_en_out, 1);
            chk(u == 0 ? "lb_rd_out" : "lbu_rd_out", rd_out, u == 0 ? 32'hFFFF_FF80 : 32'h0000_0080);
            step(); dmvalid = 1'b0; #1;
            chk("lb_after_wr_en", wr_en_out, 0);
        end

        // LH offset 2
        set_instr(5'd12, 1'b1, WB_LOAD, 32'h2000_0002, 0, 0, 0, LOAD_H, 1'b0);
        dmdata = 32'h8001_7FFF;
        step(); ex_valid_in = 1'b0; #1;
        chk("lh_stall", stall_out, 1);
        step(); dmvalid = 1'b1; #1;
        chk("lh_rd_out", rd_out, 32'hFFFF_8001);
        chk("lh_wr_en", wr_en_out, 1);
        step(); dmvalid = 1'b0;

        // LW, with the next instruction captured on the dmvalid cycle
        set_instr(5'd13, 1'b1, WB_LOAD, 32'h2000_0000, 0, 0, 0, LOAD_W, 1'b0);
        step(); ex_valid_in = 1'b0; #1;
        chk("lw_stall", stall_out, 1);
        step();
        set_instr(5'd14, 1'b1, WB_ALU, 32'hCAFE_0001, 0, 0, 0, LOAD_W, 1'b0);
        dmvalid = 1'b1; #1;
        chk("lw_stall_done", stall_out, 0);
        chk("lw_wr_en", wr_en_out, 1);
        chk("lw_rd_addr", rd_addr_out, 13);
        chk("lw_rd_out", rd_out, 32'h8001_7FFF);
        step(); ex_valid_in = 1'b0; dmvalid = 1'b0; #1;
        chk("b2b_wr_en", wr_en_out, 1);
        chk("b2b_rd_addr", rd_addr_out, 14);
        chk("b2b_rd_out", rd_out, 32'hCAFE_0001);
        step();

        // flush with a valid instruction gives a bubble
        set_instr(5'd7, 1'b1, WB_ALU, 32'h7777_7777, 0, 0, 0, LOAD_W, 1'b0);
        flush_in = 1'b1;
        step(); ex_valid_in = 1'b0; flush_in = 1'b0; #1;
        chk("flush_wr_en", wr_en_out, 0);
        chk("flush_rd_addr", rd_addr_out, 0);
        step();

        // flush during LOAD_WAIT does not kill the load
        set_instr(5'd15, 1'b1, WB_LOAD, 32'h3000_0000, 0, 0, 0, LOAD_W, 1'b0);
        dmdata = 32'h1357_9BDF;
        step();
        set_instr(5'd16, 1'b1, WB_ALU, 32'h1616_1616, 0, 0, 0, LOAD_W, 1'b0);
        flush_in = 1'b1; #1;
        chk("flush_lw_stall", stall_out, 1);
        step(); dmvalid = 1'b1; #1;
        chk("flush_lw_wr_en", wr_en_out, 1);
        chk("flush_lw_rd_addr", rd_addr_out, 15);
        chk("flush_lw_rd_out", rd_out, 32'h1357_9BDF);
        step(); ex_valid_in = 1'b0; flush_in = 1'b0; dmvalid = 1'b0; #1;
        chk("flush_lw_next_wr_en", wr_en_out, 0);
        chk("flush_lw_x15", tb_rf[15], 32'h1357_9BDF);
        step();

        // reset in LOAD_WAIT abandons the load
        set_instr(5'd20, 1'b1, WB_LOAD, 32'h4000_0000, 0, 0, 0, LOAD_W, 1'b0);
        dmdata = 32'h2020_2020;
        step(); ex_valid_in = 1'b0; #1;
        chk("rst_lw_stall", stall_out, 1);
        rst = 1'b1;
        step(); rst = 1'b0; #1;
        chk("rst_lw_stall_after", stall_out, 0);
        chk("rst_lw_wr_en", wr_en_out, 0);
        chk("rst_lw_rd_addr", rd_addr_out, 0);
        dmvalid = 1'b1; #1;
        chk("rst_late_dmvalid_wr_en", wr_en_out, 0);
        chk("rst_late_dmvalid_stall", stall_out, 0);
        step(); dmvalid = 1'b0; #1;
        chk("rst_lw_x20", tb_rf[20], 0);

        // randomized instruction stream against the reference model
        for (int it = 0; it < 200; it++) begin
            r_rd  = 5'($urandom_range(0, 31));
            r_wen = ($urandom_range(0, 3) != 0);
            r_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) r_sel = WB_LOAD;
            r_alu = $urandom; r_imm = $urandom; r_pc4 = $urandom; r_csr = $urandom;
            r_sz  = 2'($urandom_range(0, 3));
            r_uns = 1'($urandom_range(0, 1));
            r_dm  = $urandom;
            r_dly = $urandom_range(0, 3);
            r_fl  = ($urandom_range(0, 7) == 0);
            set_instr(r_rd, r_wen, r_sel, r_alu, r_imm, r_pc4, r_csr, r_sz, r_uns);
            flush_in = r_fl;
            step(); ex_valid_in = 1'b0; flush_in = 1'b0;
            if (r_fl) begin
                #1;
                chk("rnd_flush_wr_en", wr_en_out, 0);
                chk("rnd_flush_stall", stall_out, 0);
                continue;
            end
            if (r_sel == WB_LOAD) begin
                dmdata = r_dm;
                for (int d = 0; d < r_dly; d++) begin
                    #1;
                    chk("rnd_stall", stall_out, 1);
                    chk("rnd_wait_wr_en", wr_en_out, 0);
                    step();
                end
                dmvalid = 1'b1;
            end
            r_exp = r_wen && (r_rd != 5'd0);
            r_val = ref_rd(r_sel, r_alu, r_imm, r_pc4, r_csr, r_dm, r_sz, r_uns);
            #1;
            chk("rnd_stall_clear", stall_out, 0);
            chk("rnd_wr_en", wr_en_out, r_exp);
            chk("rnd_rd_addr", rd_addr_out, r_rd);
            chk("rnd_rd_out", rd_out, r_val);
            if (r_exp) begin
                model_rf[r_rd] = r_val;
                touched[r_rd]  = 1'b1;
            end
            step(); dmvalid = 1'b0;
        end
        #1;
        for (int i = 0; i < 32; i++) begin
            if (touched[i]) chk($sformatf("rnd_rf_x%0d", i), tb_rf[i], model_rf[i]);
        end
        chk("rnd_x0_written", x0_written, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
